// File: rtl/bomb_pkg.sv
// Shared types and default constants for the bomb pool.
// The slot FSM and the pool allocator both import this package.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    EXPLODED = 2'd2
  } slot_state_t;

  typedef logic signed [10:0] coord_t;

  localparam int FUSE_SEC_DEF     = 4;
  localparam int BLAST_FRAMES_DEF = 60;
  localparam int NUM_BOMBS_DEF    = 4;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> ARMED (fuse in seconds) -> EXPLODED (blast in frames) -> IDLE.
// Holds the latched position and both countdown counters.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_SEC     = FUSE_SEC_DEF,
  parameter int BLAST_FRAMES = BLAST_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        alloc,
  input  logic        tick,
  input  logic        frame,
  input  logic        force_explode,
  input  coord_t      req_x,
  input  coord_t      req_y,
  output slot_state_t state,
  output coord_t      pos_x,
  output coord_t      pos_y
);

  localparam int FW = $clog2(FUSE_SEC + 1);
  localparam int BW = $clog2(BLAST_FRAMES + 1);
  localparam logic [FW-1:0] FUSE_INIT  = FW'(FUSE_SEC);
  localparam logic [BW-1:0] BLAST_LAST = BW'(BLAST_FRAMES - 1);
  localparam logic [BW-1:0] BLAST_MAX  = BW'(BLAST_FRAMES);

  slot_state_t   state_reg, state_next;
  logic [FW-1:0] fuse_reg, fuse_next;
  logic [BW-1:0] blast_reg, blast_next;
  coord_t        x_reg, x_next, y_reg, y_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= IDLE;
      fuse_reg  <= '0;
      blast_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      fuse_reg  <= fuse_next;
      blast_reg <= blast_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fuse_next  = fuse_reg;
    blast_next = blast_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        if (alloc) begin
          state_next = ARMED;
          fuse_next  = FUSE_INIT;
          x_next     = req_x;
          y_next     = req_y;
        end
      end
      ARMED: begin
        // A forced explosion wins over a tick arriving in the same cycle.
        if (force_explode || (tick && fuse_reg <= FW'(1))) begin
          state_next = EXPLODED;
          fuse_next  = '0;
          blast_next = '0;
        end else if (tick) begin
          fuse_next = fuse_reg - FW'(1);
        end
      end
      EXPLODED: begin
        if (frame) begin
          if (blast_reg >= BLAST_LAST) begin
            state_next = IDLE;
            blast_next = BLAST_MAX;
          end else begin
            blast_next = blast_reg + BW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign state = state_reg;
  assign pos_x = x_reg;
  assign pos_y = y_reg;

endmodule

// File: rtl/bomb_pool_fsm.sv
// Pool of NUM_BOMBS bomb slots with lowest-index allocation, duplicate rejection,
// chain reaction and remote detonation; status outputs come from registered slot state.
module bomb_pool_fsm
  import bomb_pkg::*;
#(
  parameter int NUM_BOMBS    = NUM_BOMBS_DEF,
  parameter int FUSE_SEC     = FUSE_SEC_DEF,
  parameter int BLAST_FRAMES = BLAST_FRAMES_DEF
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           oneSecCounter,
  input  logic                           bomb_req,
  input  coord_t                         topLeftX_in,
  input  coord_t                         topLeftY_in,
  input  logic                           detonate_all,
  input  logic [NUM_BOMBS-1:0]           chain_hit,
  output logic                           bomb_ack,
  output logic                           bomb_nack,
  output logic                           pool_full,
  output logic [$clog2(NUM_BOMBS+1)-1:0] active_count,
  output logic [NUM_BOMBS-1:0]           bomb_exist,
  output logic [NUM_BOMBS-1:0]           bomb_exploded,
  output coord_t [NUM_BOMBS-1:0]         topLeftX_out,
  output coord_t [NUM_BOMBS-1:0]         topLeftY_out
);

  localparam int CW = $clog2(NUM_BOMBS + 1);

  slot_state_t          slot_state [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] idle_vec, armed_vec, exploded_vec, dup_vec, pick_vec, alloc_vec;
  logic                 accept, found;
  logic                 ack_reg, nack_reg;
  logic [CW-1:0]        count_next;

  generate
    for (genvar gi = 0; gi < NUM_BOMBS; gi++) begin : g_slot
      bomb_slot #(
        .FUSE_SEC     (FUSE_SEC),
        .BLAST_FRAMES (BLAST_FRAMES)
      ) u_slot (
        .clk           (clk),
        .resetN        (resetN),
        .alloc         (alloc_vec[gi]),
        .tick          (oneSecCounter),
        .frame         (startOfFrame),
        .force_explode (chain_hit[gi] | detonate_all),
        .req_x         (topLeftX_in),
        .req_y         (topLeftY_in),
        .state         (slot_state[gi]),
        .pos_x         (topLeftX_out[gi]),
        .pos_y         (topLeftY_out[gi])
      );
      assign idle_vec[gi]     = (slot_state[gi] == IDLE);
      assign armed_vec[gi]    = (slot_state[gi] == ARMED);
      assign exploded_vec[gi] = (slot_state[gi] == EXPLODED);
      // Only live (ARMED) bombs block a new one at the same spot.
      assign dup_vec[gi] = armed_vec[gi] && (topLeftX_out[gi] == topLeftX_in)
                           && (topLeftY_out[gi] == topLeftY_in);
    end
  endgenerate

  always_comb begin
    pick_vec = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (idle_vec[i] && !found) begin
        pick_vec[i] = 1'b1;
        found       = 1'b1;
      end
    end
    accept    = found && !(|dup_vec);
    alloc_vec = (bomb_req && accept) ? pick_vec : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ack_reg  <= 1'b0;
      nack_reg <= 1'b0;
    end else begin
      ack_reg  <= bomb_req && accept;
      nack_reg <= bomb_req && !accept;
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (!idle_vec[i]) count_next = count_next + CW'(1);
    end
  end

  assign bomb_ack      = ack_reg;
  assign bomb_nack     = nack_reg;
  assign pool_full     = ~(|idle_vec);
  assign active_count  = count_next;
  assign bomb_exist    = armed_vec;
  assign bomb_exploded = exploded_vec;

endmodule

// File: tb/tb_bomb_pool_fsm.sv
// Directed bench for bomb_pool_fsm: allocation, rejection, fuse, chain, detonation, reset.
module tb_bomb_pool_fsm;
  import bomb_pkg::*;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          oneSecCounter = 1'b0;
  logic          bomb_req = 1'b0;
  logic          detonate_all = 1'b0;
  coord_t        topLeftX_in = '0;
  coord_t        topLeftY_in = '0;
  logic [3:0]    chain_hit = '0;
  logic          bomb_ack, bomb_nack, pool_full;
  logic [2:0]    active_count;
  logic [3:0]    bomb_exist, bomb_exploded;
  coord_t [3:0]  topLeftX_out, topLeftY_out;

  int tests_run = 0;
  int tests_failed = 0;

  bomb_pool_fsm #(.NUM_BOMBS(4), .FUSE_SEC(4), .BLAST_FRAMES(60)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .oneSecCounter(oneSecCounter),
    .bomb_req(bomb_req), .topLeftX_in(topLeftX_in), .topLeftY_in(topLeftY_in),
    .detonate_all(detonate_all), .chain_hit(chain_hit), .bomb_ack(bomb_ack),
    .bomb_nack(bomb_nack), .pool_full(pool_full), .active_count(active_count),
    .bomb_exist(bomb_exist), .bomb_exploded(bomb_exploded),
    .topLeftX_out(topLeftX_out), .topLeftY_out(topLeftY_out)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int x, input int y);
    bomb_req = 1'b1;
    topLeftX_in = coord_t'(x);
    topLeftY_in = coord_t'(y);
    step;
    bomb_req = 1'b0;
    $display("[TB] req (%0d,%0d) ack=%0b nack=%0b exist=%b", x, y, bomb_ack, bomb_nack, bomb_exist);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      oneSecCounter = 1'b1;
      step;
      oneSecCounter = 1'b0;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      step;
      startOfFrame = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    step; step;
    tests_run++; if ({bomb_ack, bomb_nack, pool_full} !== 3'b000) begin tests_failed++; $display("FAIL rst_flags got %b want 000", {bomb_ack, bomb_nack, pool_full}); end
    tests_run++; if (active_count !== 3'd0) begin tests_failed++; $display("FAIL rst_count got %0d want 0", active_count); end
    tests_run++; if ({bomb_exist, bomb_exploded} !== 8'h00) begin tests_failed++; $display("FAIL rst_state got %b want 0", {bomb_exist, bomb_exploded}); end
    tests_run++; if (topLeftX_out[0] !== 11'sd0 || topLeftY_out[0] !== 11'sd0) begin tests_failed++; $display("FAIL rst_pos got %0d,%0d want 0,0", topLeftX_out[0], topLeftY_out[0]); end
    resetN = 1'b1;
    step;
  endtask

  task automatic test_single;
    request(100, 50);
    tests_run++; if (bomb_ack !== 1'b1 || bomb_nack !== 1'b0) begin tests_failed++; $display("FAIL s_ack got %b want 10", {bomb_ack, bomb_nack}); end
    tests_run++; if (bomb_exist !== 4'b0001) begin tests_failed++; $display("FAIL s_exist got %b want 0001", bomb_exist); end
    tests_run++; if (topLeftX_out[0] !== 11'sd100 || topLeftY_out[0] !== 11'sd50) begin tests_failed++; $display("FAIL s_pos got %0d,%0d want 100,50", topLeftX_out[0], topLeftY_out[0]); end
    step;
    tests_run++; if (bomb_ack !== 1'b0) begin tests_failed++; $display("FAIL s_ack_pulse got %b want 0", bomb_ack); end
    ticks(3);
    tests_run++; if (bomb_exist !== 4'b0001 || bomb_exploded !== 4'b0000) begin tests_failed++; $display("FAIL s_fuse3 got %b/%b want 0001/0000", bomb_exist, bomb_exploded); end
    ticks(1);
    tests_run++; if (bomb_exist !== 4'b0000 || bomb_exploded !== 4'b0001) begin tests_failed++; $display("FAIL s_fuse4 got %b/%b want 0000/0001", bomb_exist, bomb_exploded); end
    frames(59);
    tests_run++; if (bomb_exploded !== 4'b0001) begin tests_failed++; $display("FAIL s_blast59 got %b want 0001", bomb_exploded); end
    frames(1);
    tests_run++; if (bomb_exploded !== 4'b0000 || active_count !== 3'd0) begin tests_failed++; $display("FAIL s_blast60 got %b cnt %0d want 0000 cnt 0", bomb_exploded, active_count); end
    tests_run++; if (topLeftX_out[0] !== 11'sd100) begin tests_failed++; $display("FAIL s_hold got %0d want 100", topLeftX_out[0]); end
  endtask

  task automatic test_pool_full;
    logic [3:0] want;
    for (int i = 0; i < 4; i++) begin
      request(200 + i * 10, 20);
      want = 4'((1 << (i + 1)) - 1);
      tests_run++; if (bomb_ack !== 1'b1 || bomb_exist !== want) begin tests_failed++; $display("FAIL p_fill%0d got ack %b exist %b want 1 %b", i, bomb_ack, bomb_exist, want); end
    end
    tests_run++; if (pool_full !== 1'b1 || active_count !== 3'd4) begin tests_failed++; $display("FAIL p_full got %b cnt %0d want 1 cnt 4", pool_full, active_count); end
    request(300, 300);
    tests_run++; if (bomb_nack !== 1'b1 || bomb_ack !== 1'b0) begin tests_failed++; $display("FAIL p_nack got %b want 01", {bomb_ack, bomb_nack}); end
    tests_run++; if (bomb_exist !== 4'b1111 || topLeftX_out[3] !== 11'sd230) begin tests_failed++; $display("FAIL p_nochange got %b x3 %0d want 1111 230", bomb_exist, topLeftX_out[3]); end
    chain_hit = 4'b0010;
    step;
    chain_hit = '0;
    tests_run++; if (bomb_exploded !== 4'b0010 || bomb_exist !== 4'b1101 || pool_full !== 1'b1) begin tests_failed++; $display("FAIL p_chain1 got %b/%b full %b want 0010/1101 1", bomb_exploded, bomb_exist, pool_full); end
    frames(59);
    // Slot 1 leaves EXPLODED in this cycle, so a request here still sees a full pool.
    startOfFrame = 1'b1;
    request(310, 300);
    startOfFrame = 1'b0;
    tests_run++; if (bomb_nack !== 1'b1 || bomb_exploded !== 4'b0000 || pool_full !== 1'b0) begin tests_failed++; $display("FAIL p_sameedge got nack %b expl %b full %b want 1 0000 0", bomb_nack, bomb_exploded, pool_full); end
    request(310, 300);
    tests_run++; if (bomb_ack !== 1'b1 || bomb_exist !== 4'b1111 || topLeftX_out[1] !== 11'sd310) begin tests_failed++; $display("FAIL p_reuse got ack %b exist %b x1 %0d want 1 1111 310", bomb_ack, bomb_exist, topLeftX_out[1]); end
    detonate_all = 1'b1;
    step;
    detonate_all = 1'b0;
    frames(60);
    tests_run++; if (active_count !== 3'd0) begin tests_failed++; $display("FAIL p_clean got %0d want 0", active_count); end
  endtask

  task automatic test_duplicate;
    request(100, 50);
    tests_run++; if (bomb_ack !== 1'b1 || bomb_exist !== 4'b0001) begin tests_failed++; $display("FAIL d_first got %b %b want 1 0001", bomb_ack, bomb_exist); end
    request(100, 50);
    tests_run++; if (bomb_nack !== 1'b1 || bomb_exist !== 4'b0001) begin tests_failed++; $display("FAIL d_dup got nack %b exist %b want 1 0001", bomb_nack, bomb_exist); end
    request(100, 51);
    tests_run++; if (bomb_ack !== 1'b1 || bomb_exist !== 4'b0011 || topLeftY_out[1] !== 11'sd51) begin tests_failed++; $display("FAIL d_near got ack %b exist %b y1 %0d want 1 0011 51", bomb_ack, bomb_exist, topLeftY_out[1]); end
  endtask

  task automatic test_chain_priority;
    ticks(1);
    chain_hit = 4'b0101;
    oneSecCounter = 1'b1;
    step;
    chain_hit = '0;
    oneSecCounter = 1'b0;
    tests_run++; if (bomb_exploded !== 4'b0001 || bomb_exist !== 4'b0010) begin tests_failed++; $display("FAIL c_hit got %b/%b want 0001/0010", bomb_exploded, bomb_exist); end
    frames(59);
    tests_run++; if (bomb_exploded !== 4'b0001) begin tests_failed++; $display("FAIL c_blast59 got %b want 0001", bomb_exploded); end
    frames(1);
    tests_run++; if (bomb_exploded !== 4'b0000 || bomb_exist !== 4'b0010) begin tests_failed++; $display("FAIL c_blast60 got %b/%b want 0000/0010", bomb_exploded, bomb_exist); end
    ticks(1);
    tests_run++; if (bomb_exist !== 4'b0010) begin tests_failed++; $display("FAIL c_fuse1 got %b want 0010", bomb_exist); end
    ticks(1);
    tests_run++; if (bomb_exploded !== 4'b0010) begin tests_failed++; $display("FAIL c_fuse0 got %b want 0010", bomb_exploded); end
    frames(30);
    chain_hit = 4'b0010;
    step;
    chain_hit = '0;
    frames(29);
    tests_run++; if (bomb_exploded !== 4'b0010) begin tests_failed++; $display("FAIL c_rehit59 got %b want 0010", bomb_exploded); end
    frames(1);
    tests_run++; if (bomb_exploded !== 4'b0000 || active_count !== 3'd0) begin tests_failed++; $display("FAIL c_rehit60 got %b cnt %0d want 0000 0", bomb_exploded, active_count); end
  endtask

  task automatic test_detonate_all;
    request(10, 10);
    request(20, 10);
    request(30, 10);
    tests_run++; if (bomb_exist !== 4'b0111) begin tests_failed++; $display("FAIL a_arm got %b want 0111", bomb_exist); end
    detonate_all = 1'b1;
    step;
    detonate_all = 1'b0;
    tests_run++; if (bomb_exploded !== 4'b0111 || bomb_exist !== 4'b0000) begin tests_failed++; $display("FAIL a_det got %b/%b want 0111/0000", bomb_exploded, bomb_exist); end
    frames(59);
    tests_run++; if (bomb_exploded !== 4'b0111) begin tests_failed++; $display("FAIL a_blast59 got %b want 0111", bomb_exploded); end
    frames(1);
    tests_run++; if (bomb_exploded !== 4'b0000 || active_count !== 3'd0) begin tests_failed++; $display("FAIL a_blast60 got %b cnt %0d want 0000 0", bomb_exploded, active_count); end
  endtask

  task automatic test_reset_mid;
    request(70, 80);
    request(90, 80);
    detonate_all = 1'b1;
    step;
    detonate_all = 1'b0;
    frames(5);
    tests_run++; if (active_count !== 3'd2 || bomb_exploded !== 4'b0011) begin tests_failed++; $display("FAIL m_pre got cnt %0d expl %b want 2 0011", active_count, bomb_exploded); end
    #2;
    resetN = 1'b0;
    #1;
    tests_run++; if (bomb_exploded !== 4'b0000 || active_count !== 3'd0 || pool_full !== 1'b0) begin tests_failed++; $display("FAIL m_async got expl %b cnt %0d full %b want 0000 0 0", bomb_exploded, active_count, pool_full); end
    tests_run++; if (topLeftX_out[0] !== 11'sd0 || topLeftX_out[1] !== 11'sd0) begin tests_failed++; $display("FAIL m_pos got %0d,%0d want 0,0", topLeftX_out[0], topLeftX_out[1]); end
    step;
    resetN = 1'b1;
    step;
    request(50, 60);
    tests_run++; if (bomb_ack !== 1'b1 || bomb_exist !== 4'b0001 || topLeftX_out[0] !== 11'sd50) begin tests_failed++; $display("FAIL m_req got ack %b exist %b x0 %0d want 1 0001 50", bomb_ack, bomb_exist, topLeftX_out[0]); end
    ticks(3);
    tests_run++; if (bomb_exist !== 4'b0001) begin tests_failed++; $display("FAIL m_fuse3 got %b want 0001", bomb_exist); end
    ticks(1);
    tests_run++; if (bomb_exploded !== 4'b0001) begin tests_failed++; $display("FAIL m_fuse4 got %b want 0001", bomb_exploded); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_pool_full;
    test_duplicate;
    test_chain_priority;
    test_detonate_all;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bomb_pool_fsm.md
Name: bomb_pool_fsm

Overview:
- Multi-slot bomb manager for the game VGA layer; generalises the single-bomb fuse/explosion sequencer.
- Holds up to NUM_BOMBS independent bombs, each with a latched position, a fuse countdown in seconds and an explosion display window in frames.
- Adds pool allocation, duplicate-position rejection, chain reaction and remote detonation.
- Sits between player/bomb-request logic and the bomb/explosion drawing and collision blocks.

Parameters:
- NUM_BOMBS, 4, number of independent bomb slots (1..8).
- FUSE_SEC, 4, oneSecCounter pulses from arming to explosion (>=1).
- BLAST_FRAMES, 60, startOfFrame pulses an explosion stays displayed (>=1).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous reset, active-low.
- startOfFrame  in  1  one-cycle pulse at each frame start.
- oneSecCounter  in  1  one-cycle pulse once per second.
- bomb_req  in  1  request to place a bomb at topLeftX_in/topLeftY_in; level-sampled every cycle.
- topLeftX_in  in  11 signed  requested bomb X.
- topLeftY_in  in  11 signed  requested bomb Y.
- detonate_all  in  1  remote detonation of every ARMED slot.
- chain_hit  in  NUM_BOMBS  per-slot blast contact from collision logic; forces early explosion.
- bomb_ack  out  1  one-cycle pulse, request accepted.
- bomb_nack  out  1  one-cycle pulse, request rejected (pool full or duplicate position).
- pool_full  out  1  no slot in IDLE.
- active_count  out  $clog2(NUM_BOMBS+1)  number of non-IDLE slots.
- bomb_exist  out  NUM_BOMBS  slot i is ARMED.
- bomb_exploded  out  NUM_BOMBS  slot i is EXPLODED.
- topLeftX_out  out  NUM_BOMBS x 11 signed  latched X per slot.
- topLeftY_out  out  NUM_BOMBS x 11 signed  latched Y per slot.

Behaviour:
- Reset: every slot IDLE, coordinates 0, counters 0. All outputs 0; pool_full=0 (1 only if NUM_BOMBS=0, which is disallowed).
- Reset mid-operation clears all slots immediately. There is no pending-request memory.
- Per-slot states: IDLE, ARMED, EXPLODED.
- IDLE -> ARMED when the slot is allocated.
- ARMED -> EXPLODED when the fuse expires, chain_hit[i]=1, or detonate_all=1.
- EXPLODED -> IDLE after BLAST_FRAMES frame pulses.
- Allocation, evaluated each cycle bomb_req=1, from registered state only:
  - If any ARMED slot already has identical X and Y: reject.
  - Else if no IDLE slot: reject.
  - Else take the lowest-index IDLE slot.
- Accepted at cycle T: at T+1 the slot is ARMED, bomb_exist[i]=1, X/Y latched, fuse=FUSE_SEC, bomb_ack=1 for exactly that cycle.
- Rejected at cycle T: bomb_nack=1 at T+1; no slot changes.
- Held bomb_req is re-evaluated every cycle. The requester must drop it after ack or nack.
- Fuse: each oneSecCounter pulse while ARMED decrements the fuse. The pulse seen with fuse==1 moves the slot to EXPLODED next cycle, with the blast counter cleared.
- A slot armed in cycle T ignores a tick in cycle T.
- chain_hit[i] or detonate_all while ARMED: EXPLODED next cycle, taking priority over a tick in the same cycle.
- chain_hit/detonate_all on IDLE or EXPLODED slots are ignored. A re-hit does not extend the blast.
- Blast: each startOfFrame pulse while EXPLODED increments the blast counter. The pulse that reaches BLAST_FRAMES returns the slot to IDLE next cycle, clearing bomb_exploded[i].
- X/Y outputs hold their last value while IDLE.
- A slot leaving EXPLODED in cycle T is allocatable from cycle T+1, never within T.
- Chain propagation is one hop per cycle, via external collision logic feeding chain_hit.
- pool_full and active_count are derived from registered slot state, consistent with bomb_exist|bomb_exploded.
- Counter widths: fuse $clog2(FUSE_SEC+1), blast $clog2(BLAST_FRAMES+1); saturating, never wrapping.

Decomposition:
- Shared package bomb_pkg holds:
  - slot_state_t enum (IDLE, ARMED, EXPLODED).
  - coord_t (logic signed [10:0]).
  - Default constants FUSE_SEC_DEF=4, BLAST_FRAMES_DEF=60, NUM_BOMBS_DEF=4.
- Sub-module bomb_slot holds one slot FSM with its counters and position registers. Its inputs are alloc, tick, frame, force_explode and the coordinates; its outputs are state and position.
- bomb_pool_fsm generates NUM_BOMBS instances and contains the allocator, duplicate check and status outputs.

Test Plan:
1. Reset, then bomb_req one cycle at (100,50) -> ack next cycle; slot0 bomb_exist=1, X=100, Y=50. After 4 sec pulses bomb_exploded[0]=1 for 60 frame pulses, then slot0 IDLE, active_count=0.
2. Four requests at distinct positions, then a fifth -> slots 0..3 filled in order, pool_full=1, fifth gets nack with no state change. After slot1 returns IDLE, a new request lands in slot1.
3. Request at (100,50) while slot0 ARMED at (100,50) -> nack. Request at (100,51) -> ack into slot1.
4. Slot0 fuse=3, chain_hit[0] pulsed in the same cycle as oneSecCounter -> slot0 EXPLODED next cycle, blast counter 0. chain_hit[2] on an IDLE slot -> no change.
5. Three slots ARMED, detonate_all one cycle -> all three bomb_exploded=1 on the same cycle. They return to IDLE together after 60 frames.
6. resetN low mid-blast with two active slots -> all outputs 0 asynchronously. After release, first request -> slot0 with a full 4-second fuse.
